vga_sync_gen: RTL and testbench

Raster timing generator for the TinyQV VGA peripheral. It sits directly upstream of the peripheral's pixel/VRAM stage. It produces the beam position (x, y), the sync pulses, the blank flag and a frame interrupt, all from one pair of counters. The default mode is 1024x768@60 (1344x806 total) at the 64 MHz project clock.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_sync_gen.sv | 86 ++++++++
 tb/tb_vga_sync_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 1024x768@60 raster timing constants and counter widths shared by
// the VGA sync generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 32'd1024;
    localparam int unsigned H_FRONT   = 32'd24;
    localparam int unsigned H_SYNC    = 32'd136;
    localparam int unsigned H_BACK    = 32'd160;
    localparam int unsigned V_VISIBLE = 32'd768;
    localparam int unsigned V_FRONT   = 32'd3;
    localparam int unsigned V_SYNC    = 32'd6;
    localparam int unsigned V_BACK    = 32'd29;
    localparam logic        SYNC_ACTIVE = 1'b0;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned X_W = 32'd11;
    localparam int unsigned Y_W = 32'd10;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync and blank decoded from
// the next count so they are registered in step with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL       = H_TOTAL,
    parameter int unsigned VISIBLE     = H_VISIBLE,
    parameter int unsigned SYNC_START  = H_SYNC_START,
    parameter int unsigned SYNC_END    = H_SYNC_END,
    parameter int unsigned W           = X_W,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap,
    output logic         sync,
    output logic         blank
);

    localparam logic [W-1:0] LAST  = W'(TOTAL - 32'd1);
    localparam logic [W-1:0] ONE   = W'(32'd1);
    // One extra bit so a boundary equal to 2**W still compares correctly.
    localparam logic [W:0]   VIS_L = (W+1)'(VISIBLE);
    localparam logic [W:0]   SS_L  = (W+1)'(SYNC_START);
    localparam logic [W:0]   SE_L  = (W+1)'(SYNC_END);

    logic [W-1:0] count_q, count_d;
    logic         sync_q, sync_d;
    logic         blank_q, blank_d;
    logic         wrap_s;

    always_comb begin
        wrap_s = enable && (count_q == LAST);
        if (wrap_s) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
        sync_d  = (({1'b0, count_d} >= SS_L) && ({1'b0, count_d} < SE_L)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        blank_d = ({1'b0, count_d} >= VIS_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= ~SYNC_ACTIVE;
            blank_q <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            blank_q <= blank_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign wrap       = wrap_s;
    assign sync       = sync_q;
    assign blank      = blank_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: beam position, syncs, blank and sticky frame
// interrupt. Define VGA_HBLANK_IRQ_EN for an extra per-visible-line interrupt.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cli,
    output logic [vga_timing_pkg::X_W-1:0]    x,
    output logic [vga_timing_pkg::Y_W-1:0]    y,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              blank,
    output logic                              interrupt
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [X_W-1:0] X_VIS = X_W'(H_VISIBLE);
    localparam logic [Y_W-1:0] Y_VIS = Y_W'(V_VISIBLE);

    if ((H_TOT > 32'd2048) || (V_TOT > 32'd1024)) begin : g_mode_check
        $error("vga_sync_gen: mode needs H_TOTAL <= 2048 and V_TOTAL <= 1024");
    end

    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           h_wrap, v_wrap_unused;
    logic           h_blank, v_blank;
    logic           irq_set;
    logic           interrupt_q, interrupt_d;

    vga_axis_counter #(
        .TOTAL(H_TOT), .VISIBLE(H_VISIBLE), .SYNC_START(HS_START), .SYNC_END(HS_END),
        .W(X_W), .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_h_axis (
        .clk(clk), .rst(rst), .enable(1'b1),
        .count(x), .count_next(x_next), .wrap(h_wrap), .sync(hsync), .blank(h_blank)
    );

    // The vertical axis only advances on the horizontal wrap.
    vga_axis_counter #(
        .TOTAL(V_TOT), .VISIBLE(V_VISIBLE), .SYNC_START(VS_START), .SYNC_END(VS_END),
        .W(Y_W), .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_v_axis (
        .clk(clk), .rst(rst), .enable(h_wrap),
        .count(y), .count_next(y_next), .wrap(v_wrap_unused), .sync(vsync), .blank(v_blank)
    );

    assign blank = h_blank | v_blank;

    // Set is decoded from the next position so it lands with (0, V_VISIBLE); set beats cli.
    always_comb begin
        irq_set = (x_next == '0) && (y_next == Y_VIS);
`ifdef VGA_HBLANK_IRQ_EN
        irq_set = irq_set || ((x_next == X_VIS) && (y_next < Y_VIS));
`endif
        interrupt_d = irq_set || (interrupt_q && !cli);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            interrupt_q <= 1'b0;
        end else begin
            interrupt_q <= interrupt_d;
        end
    end

    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-mode instance plus a small positive-sync
// mode instance, both checked every cycle against a linear-position model.
module tb_vga_sync_gen;

    localparam int D_HV = 1024, D_HF = 24, D_HS = 136, D_HB = 160;
    localparam int D_VV = 768,  D_VF = 3,  D_VS = 6,   D_VB = 29;
    localparam int D_HT = D_HV + D_HF + D_HS + D_HB;
    localparam int D_VT = D_VV + D_VF + D_VS + D_VB;
    localparam int S_HV = 40, S_HF = 4, S_HS = 8, S_HB = 12;
    localparam int S_VV = 30, S_VF = 2, S_VS = 3, S_VB = 5;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cli = 1'b0;

    logic [10:0] x_d, x_s;
    logic [9:0]  y_d, y_s;
    logic        hs_d, vs_d, bl_d, irq_d;
    logic        hs_s, vs_s, bl_s, irq_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mvalid = 1'b0;
    bit mirq_d = 1'b0;
    bit mirq_s = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen dut_def (
        .clk(clk), .rst(rst), .cli(cli), .x(x_d), .y(y_d),
        .hsync(hs_d), .vsync(vs_d), .blank(bl_d), .interrupt(irq_d)
    );

    vga_sync_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .SYNC_ACTIVE(1'b1)
    ) dut_small (
        .clk(clk), .rst(rst), .cli(cli), .x(x_s), .y(y_s),
        .hsync(hs_s), .vsync(vs_s), .blank(bl_s), .interrupt(irq_s)
    );

    function automatic bit irq_set_at(int c, int ht, int vt, int hv, int vv);
        int p, px, py;
        bit s;
        p  = c % (ht * vt);
        px = p % ht;
        py = p / ht;
        s  = (px == 0) && (py == vv);
`ifdef VGA_HBLANK_IRQ_EN
        s  = s || ((px == hv) && (py < vv));
`endif
        return s;
    endfunction

    // Model: cycles since reset release fully determine position; irq is a sticky bit.
    always @(posedge clk) begin
        if (rst) begin
            cyc    <= 0;
            mirq_d <= 1'b0;
            mirq_s <= 1'b0;
            mvalid <= 1'b1;
        end else begin
            cyc    <= cyc + 1;
            mirq_d <= irq_set_at(cyc + 1, D_HT, D_VT, D_HV, D_VV) | (mirq_d & ~cli);
            mirq_s <= irq_set_at(cyc + 1, S_HT, S_VT, S_HV, S_VV) | (mirq_s & ~cli);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_mode(input string nm, input int ht, input int vt, input int hv, input int hf,
                            input int hs, input int vv, input int vf, input int vs, input bit sa,
                            input bit mirq, input logic [10:0] ax, input logic [9:0] ay,
                            input logic ahs, input logic avs, input logic abl, input logic airq);
        int p, ex, ey;
        bit ehs, evs, ebl;
        p   = cyc % (ht * vt);
        ex  = p % ht;
        ey  = p / ht;
        ehs = (ex >= hv + hf && ex < hv + hf + hs) ? sa : ~sa;
        evs = (ey >= vv + vf && ey < vv + vf + vs) ? sa : ~sa;
        ebl = (ex >= hv) || (ey >= vv);
        chk({nm, ".x"}, 32'(ax), ex);
        chk({nm, ".y"}, 32'(ay), ey);
        chk({nm, ".hsync"}, 32'(ahs), 32'(ehs));
        chk({nm, ".vsync"}, 32'(avs), 32'(evs));
        chk({nm, ".blank"}, 32'(abl), 32'(ebl));
        chk({nm, ".irq"}, 32'(airq), 32'(mirq));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                cmp_mode("def", D_HT, D_VT, D_HV, D_HF, D_HS, D_VV, D_VF, D_VS, 1'b0, mirq_d,
                         x_d, y_d, hs_d, vs_d, bl_d, irq_d);
                cmp_mode("small", S_HT, S_VT, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS, 1'b1, mirq_s,
                         x_s, y_s, hs_s, vs_s, bl_s, irq_s);
            end
        end
    end

    // mode 0: cli low, 1: sparse random cli pulses, 2: cli held high
    task automatic run_to(input int target, input int mode);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            case (mode)
                0:       cli = 1'b0;
                1:       cli = ($urandom_range(0, 39) == 0);
                default: cli = 1'b1;
            endcase
            @(negedge clk);
            guard++;
        end
        chk("run_to.cyc", cyc, target);
    endtask

    task automatic reset_checks();
        chk("rst.x_d", 32'(x_d), 0);
        chk("rst.y_d", 32'(y_d), 0);
        chk("rst.hs_d", 32'(hs_d), 1);
        chk("rst.vs_d", 32'(vs_d), 1);
        chk("rst.bl_d", 32'(bl_d), 0);
        chk("rst.irq_d", 32'(irq_d), 0);
        chk("rst.hs_s", 32'(hs_s), 0);
        chk("rst.irq_s", 32'(irq_s), 0);
    endtask

    initial begin
        rst = 1'b1;
        cli = 1'b0;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        @(negedge clk);
        chk("first.x_d", 32'(x_d), 1);
        chk("first.x_s", 32'(x_s), 1);

`ifdef VGA_HBLANK_IRQ_EN
        run_to(40, 0);
        chk("hirq.set0", 32'(irq_s), 1);
        cli = 1'b1;
        @(negedge clk);
        cli = 1'b0;
        chk("hirq.clr", 32'(irq_s), 0);
        run_to(104, 0);
        chk("hirq.set1", 32'(irq_s), 1);
`endif

        run_to(1024, 1);
        chk("line.blank_rise", 32'(bl_d), 1);
        run_to(1047, 1);
        chk("line.hs_1047", 32'(hs_d), 1);
        run_to(1048, 1);
        chk("line.hs_1048", 32'(hs_d), 0);
        run_to(1183, 1);
        chk("line.hs_1183", 32'(hs_d), 0);
        run_to(1184, 1);
        chk("line.hs_1184", 32'(hs_d), 1);
        run_to(1343, 1);
        chk("line.x_last", 32'(x_d), 1343);
        run_to(1344, 1);
        chk("line.x_wrap", 32'(x_d), 0);
        chk("line.y_inc", 32'(y_d), 1);
        chk("line.blank_fall", 32'(bl_d), 0);

        run_to(1900, 1);
        run_to(1920, 0);
        chk("irq.set", 32'(irq_s), 1);
        chk("irq.blank", 32'(bl_s), 1);
        chk("irq.y", 32'(y_s), 30);
        run_to(1950, 0);
        chk("irq.hold", 32'(irq_s), 1);
        cli = 1'b1;
        @(negedge clk);
        cli = 1'b0;
        chk("irq.clear", 32'(irq_s), 0);

        run_to(2047, 1);
        chk("frame.vs_pre", 32'(vs_s), 0);
        run_to(2048, 1);
        chk("frame.vs_on", 32'(vs_s), 1);
        chk("frame.y_on", 32'(y_s), 32);
        run_to(2239, 1);
        chk("frame.vs_last", 32'(vs_s), 1);
        run_to(2240, 1);
        chk("frame.vs_off", 32'(vs_s), 0);
        run_to(2559, 1);
        chk("frame.y_last", 32'(y_s), 39);
        run_to(2560, 1);
        chk("frame.x_wrap", 32'(x_s), 0);
        chk("frame.y_wrap", 32'(y_s), 0);
        chk("frame.blank", 32'(bl_s), 0);

        run_to(4470, 1);
        run_to(4480, 2);
        chk("irq.set_vs_cli", 32'(irq_s), 1);
        run_to(4481, 2);
        chk("irq.cli_after", 32'(irq_s), 0);
        cli = 1'b0;

        // Reset while the default-mode hsync pulse is active.
        run_to(5132, 1);
        chk("mid.hs_active", 32'(hs_d), 0);
        cli = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b0;
        @(negedge clk);
        chk("mid.first.x_d", 32'(x_d), 1);
        chk("mid.first.x_s", 32'(x_s), 1);

        run_to(6000, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
